pac_mover: RTL and testbench
============================

# pac_mover

Pac-Man position engine for the 18x5 maze. It sits directly upstream of the dot counter and feeds it `pac_x`/`pac_y`. Each step tick it advances the player one cell in the current direction, and applies a buffered turn request when the target cell is open. The block is frozen outside the play scene and re-homes on the start scene.

## Interface
Parameters:
- `STEP_BIT`, default 22: bit of `display_cnt` whose rising edge is the step tick.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `scene` in 2: 00 start, 01 play, 10 win, 11 lose.
- `display_cnt` in 27: free-running display counter.
- `btn_u`, `btn_d`, `btn_l`, `btn_r` in 1 each: debounced level buttons.
- `pac_x` out 5: column, 0..17.
- `pac_y` out 5: row, 0..4.
- `pac_dir` out 2: facing direction; 0 up, 1 down, 2 left, 3 right.
- `moving` out 1: 1 if the last step advanced, 0 if blocked.

## Operation
- **Maze.** Cell index is `x + y*18`. A 1 means wall. Row strings list x0 first:
  - r0: 000000000000000000
  - r1: 011110111111011110
  - r2: 000000000000000000
  - r3: 011110111111011110
  - r4: 000000000000000000
- **Home state.** Applies when `rst`=1, or on any clock with scene=start:
  - `pac_x`=8, `pac_y`=2
  - `pac_dir`=left
  - pending turn cleared
  - `moving`=0
  - These are the reset values of all outputs.
- **Turn request (play only).** Each clock, any pressed button loads `pend_dir`/`pend_v`=1. Priority is U>D>L>R. Releasing a button does not clear the pending request.
- **Step (play only, on the tick).** Evaluated in order:
  1. If `pend_v` and the neighbour in `pend_dir` is open: `pac_dir`<=`pend_dir`, move to that cell, `pend_v`<=0, `moving`<=1.
  2. Else if the neighbour in `pac_dir` is open: move there, `moving`<=1. The pending request is kept.
  3. Else: hold position, `moving`<=0. The pending request is kept.
- **Off-grid neighbours.**
  - y<0 or y>4 is always a wall.
  - x<0 or x>17 is handled by the tunnel logic (see Configuration).
- **Scenes win/lose.** All state freezes. Buttons and ticks are ignored.
- **Simultaneous events.**
  - A button press and a tick on the same clock: the tick evaluates the `pend_dir` registered before that clock. The new press is visible at the next tick.
  - `rst` or scene=start overrides everything.
- **Arithmetic.** Compute neighbour coordinates with 6-bit signed intermediates, then range-check. `pac_x`/`pac_y` never leave 0..17 / 0..4.

## Timing
- `tick_q` <= `display_cnt[STEP_BIT]` every clock.
- `tick` = `display_cnt[STEP_BIT]` & ~`tick_q`. It is one clock wide.
- Position, `pac_dir` and `moving` update at the posedge where `tick`=1. Latency is 0 cycles from the edge sample.
- `tick_q` is cleared by `rst`. A first sample of 1 after reset counts as an edge.
- Outputs are registered and hold between ticks. The dot counter samples them directly.
- Entering play from start: the first move occurs on the first tick after scene=01.
- `rst` mid-step: home state at that edge, and no move is taken.

## Configuration
- `PAC_TUNNEL_WRAP_EN` defined:
  - moving left from x=0 targets (17,y);
  - moving right from x=17 targets (0,y);
  - the target's wall bit applies as for any other cell.
- Not defined: x=0 left and x=17 right are walls, so the step is blocked with `moving`=0.

## Structure
- Package `pacman_pkg` holds:
  - scene codes `SCENE_START/PLAY/WIN/LOSE`;
  - direction codes `DIR_UP/DOWN/LEFT/RIGHT`;
  - `GRID_W`=18, `GRID_H`=5;
  - the 90-bit `WALL_MAP`;
  - `HOME_X`=8, `HOME_Y`=2.
- One combinational sub-module, `pac_next_cell`. It takes (x, y, dir) and returns (nx, ny, open), including wall lookup and tunnel handling.
- `pac_mover` instantiates it twice: once for the pending direction, once for the current direction.

## Test plan
- **Reset and home.** `rst` 1 cycle, then scene=play, 1 tick -> (7,2), dir left, `moving`=1.
- **Buffered turn.** At (7,2), pulse `btn_u` 1 clock. Give ticks -> (6,2), then (5,2) with `pend_v` still 1, then (5,1) with dir up and `pend_v`=0.
- **Blocked.** Continue ticks from (5,1) up -> (5,0), then hold at (5,0) with `moving`=0 and dir up.
- **Tunnel.** Starting at (0,2) moving left, 1 tick:
  - with `PAC_TUNNEL_WRAP_EN` -> (17,2), `moving`=1;
  - without -> (0,2), `moving`=0.
- **Freeze.** scene=win, 4 ticks plus `btn_d` -> position, dir and `moving` unchanged.
- **Start mid-play.** At (3,0), scene=start for 1 clock -> (8,2), left, `pend_v`=0 on the next clock.

Source files
------------

// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_pkg
//  Description : Shared scene/direction codes, maze geometry and wall map
//                for the Pac-Man position engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

  typedef enum logic [1:0] {
    SCENE_START = 2'b00,
    SCENE_PLAY  = 2'b01,
    SCENE_WIN   = 2'b10,
    SCENE_LOSE  = 2'b11
  } scene_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int GRID_W = 18;
  localparam int GRID_H = 5;

  // Bit x of each row word is column x; rows 1 and 3 carry the wall bars.
  localparam logic [17:0] ROW_OPEN = 18'b000000000000000000;
  localparam logic [17:0] ROW_BARS = 18'b011110111111011110;

  // Cell index x + y*18; row 0 occupies the least significant bits.
  localparam logic [89:0] WALL_MAP = {ROW_OPEN, ROW_BARS, ROW_OPEN, ROW_BARS, ROW_OPEN};

  localparam logic [4:0] HOME_X = 5'd8;
  localparam logic [4:0] HOME_Y = 5'd2;

  // Wall lookup for an in-range cell.
  function automatic logic is_wall(input logic [4:0] x, input logic [4:0] y);
    logic [6:0] idx;
    idx = {2'b00, x} + (7'(y) * 7'(GRID_W));
    return WALL_MAP[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pac_next_cell.sv
`default_nettype none
// ============================================================================
//  Module      : pac_next_cell
//  Description : Combinational neighbour lookup. Given a cell and a direction
//                returns the neighbour coordinates and whether it is open.
//                Define PAC_TUNNEL_WRAP_EN to make columns 0 and 17 wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module pac_next_cell
  import pacman_pkg::*;
(
  input  logic [4:0] i_x,
  input  logic [4:0] i_y,
  input  dir_t       i_dir,
  output logic [4:0] o_nx,
  output logic [4:0] o_ny,
  output logic       o_open
);

  logic signed [5:0] w_tx;
  logic signed [5:0] w_ty;
  logic              w_x_ok;
  logic              w_y_ok;

  // Signed neighbour arithmetic, range check, tunnel handling and wall lookup.
  always_comb begin
    w_tx   = $signed({1'b0, i_x});
    w_ty   = $signed({1'b0, i_y});
    w_x_ok = 1'b1;
    case (i_dir)
      DIR_UP:    w_ty = w_ty - 6'sd1;
      DIR_DOWN:  w_ty = w_ty + 6'sd1;
      DIR_LEFT:  w_tx = w_tx - 6'sd1;
      DIR_RIGHT: w_tx = w_tx + 6'sd1;
      default:   w_tx = w_tx;
    endcase
    w_y_ok = (w_ty >= 6'sd0) && (w_ty <= 6'sd4);
`ifdef PAC_TUNNEL_WRAP_EN
    if (w_tx < 6'sd0) begin
      w_tx = 6'sd17;
    end else if (w_tx > 6'sd17) begin
      w_tx = 6'sd0;
    end
`else
    if ((w_tx < 6'sd0) || (w_tx > 6'sd17)) begin
      w_x_ok = 1'b0;
    end
`endif
    // Off-grid targets report the current cell so coordinates stay in range.
    if (w_x_ok && w_y_ok) begin
      o_nx   = w_tx[4:0];
      o_ny   = w_ty[4:0];
      o_open = ~is_wall(w_tx[4:0], w_ty[4:0]);
    end else begin
      o_nx   = i_x;
      o_ny   = i_y;
      o_open = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pac_mover.sv
`default_nettype none
// ============================================================================
//  Module      : pac_mover
//  Description : Pac-Man position engine for the 18x5 maze. Advances one cell
//                per step tick, applying a buffered turn when its target is
//                open. Frozen outside play, re-homed on the start scene.
//                Optional tunnel wrap: PAC_TUNNEL_WRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pac_mover
  import pacman_pkg::*;
#(
  parameter int STEP_BIT = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  scene,
  input  logic [26:0] display_cnt,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  output logic [4:0]  pac_x,
  output logic [4:0]  pac_y,
  output logic [1:0]  pac_dir,
  output logic        moving
);

  logic [4:0] r_x;
  logic [4:0] r_y;
  dir_t       r_dir;
  dir_t       r_pend_dir;
  logic       r_pend_v;
  logic       r_moving;
  logic       r_tick_q;

  logic       w_tick;
  logic       w_btn_any;
  dir_t       w_btn_dir;
  logic [4:0] w_pend_nx;
  logic [4:0] w_pend_ny;
  logic       w_pend_open;
  logic [4:0] w_cur_nx;
  logic [4:0] w_cur_ny;
  logic       w_cur_open;

  assign w_tick = display_cnt[STEP_BIT] & ~r_tick_q;

  // Button priority encoder: up over down over left over right.
  always_comb begin
    w_btn_any = btn_u | btn_d | btn_l | btn_r;
    w_btn_dir = DIR_RIGHT;
    if (btn_u) begin
      w_btn_dir = DIR_UP;
    end else if (btn_d) begin
      w_btn_dir = DIR_DOWN;
    end else if (btn_l) begin
      w_btn_dir = DIR_LEFT;
    end
  end

  pac_next_cell u_pend_cell (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_dir  (r_pend_dir),
    .o_nx   (w_pend_nx),
    .o_ny   (w_pend_ny),
    .o_open (w_pend_open)
  );

  pac_next_cell u_cur_cell (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_dir  (r_dir),
    .o_nx   (w_cur_nx),
    .o_ny   (w_cur_ny),
    .o_open (w_cur_open)
  );

  // Step-bit edge detector history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_q <= 1'b0;
    end else begin
      r_tick_q <= display_cnt[STEP_BIT];
    end
  end

  // Position/turn state: home on reset or start, advance only in play.
  always_ff @(posedge clk) begin
    if (rst || (scene == SCENE_START)) begin
      r_x        <= HOME_X;
      r_y        <= HOME_Y;
      r_dir      <= DIR_LEFT;
      r_pend_dir <= DIR_LEFT;
      r_pend_v   <= 1'b0;
      r_moving   <= 1'b0;
    end else if (scene == SCENE_PLAY) begin
      if (w_tick) begin
        if (r_pend_v && w_pend_open) begin
          r_x      <= w_pend_nx;
          r_y      <= w_pend_ny;
          r_dir    <= r_pend_dir;
          r_pend_v <= 1'b0;
          r_moving <= 1'b1;
        end else if (w_cur_open) begin
          r_x      <= w_cur_nx;
          r_y      <= w_cur_ny;
          r_moving <= 1'b1;
        end else begin
          r_moving <= 1'b0;
        end
      end
      // A press on the tick clock is queued after the tick consumed the old request.
      if (w_btn_any) begin
        r_pend_dir <= w_btn_dir;
        r_pend_v   <= 1'b1;
      end
    end
  end

  assign pac_x   = r_x;
  assign pac_y   = r_y;
  assign pac_dir = r_dir;
  assign moving  = r_moving;

endmodule
`default_nettype wire

// File: tb/tb_pac_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pac_mover
//  Description : Directed self-checking bench for pac_mover.
//                Honours PAC_TUNNEL_WRAP_EN for the tunnel expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pac_mover;

  logic        clk;
  logic        rst;
  logic [1:0]  scene;
  logic [26:0] display_cnt;
  logic        btn_u, btn_d, btn_l, btn_r;
  logic [4:0]  pac_x, pac_y;
  logic [1:0]  pac_dir;
  logic        moving;

  int n_chk;
  int n_fail;

  localparam logic [1:0] D_UP = 2'd0, D_DN = 2'd1, D_LT = 2'd2;

  pac_mover #(.STEP_BIT(22)) dut (
    .clk         (clk),
    .rst         (rst),
    .scene       (scene),
    .display_cnt (display_cnt),
    .btn_u       (btn_u),
    .btn_d       (btn_d),
    .btn_l       (btn_l),
    .btn_r       (btn_r),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .pac_dir     (pac_dir),
    .moving      (moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One rising edge of the step bit, then let it fall.
  task automatic do_tick();
    display_cnt[22] = 1'b1;
    cyc();
    display_cnt[22] = 1'b0;
    cyc();
  endtask

  task automatic press(input logic [1:0] d);
    btn_u = (d == 2'd0);
    btn_d = (d == 2'd1);
    btn_l = (d == 2'd2);
    btn_r = (d == 2'd3);
    cyc();
    {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scene = 2'b01;
    cyc();
    rst = 1'b0;
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving, dut.r_pend_v} !== {5'd8, 5'd2, D_LT, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_home: got %0d,%0d dir%0d mv%0d pv%0d need 8,2 dir2 mv0 pv0",
               pac_x, pac_y, pac_dir, moving, dut.r_pend_v);
    end
    do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd7, 5'd2, D_LT, 1'b1}) begin
      n_fail++;
      $display("FAIL first_step: got %0d,%0d dir%0d mv%0d need 7,2 dir2 mv1", pac_x, pac_y, pac_dir, moving);
    end
  endtask

  task automatic test_buffered_turn();
    press(D_UP);
    do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving, dut.r_pend_v} !== {5'd6, 5'd2, D_LT, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL turn_t1: got %0d,%0d dir%0d mv%0d pv%0d need 6,2 dir2 mv1 pv1",
               pac_x, pac_y, pac_dir, moving, dut.r_pend_v);
    end
    do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving, dut.r_pend_v} !== {5'd5, 5'd2, D_LT, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL turn_t2: got %0d,%0d dir%0d mv%0d pv%0d need 5,2 dir2 mv1 pv1",
               pac_x, pac_y, pac_dir, moving, dut.r_pend_v);
    end
    do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving, dut.r_pend_v} !== {5'd5, 5'd1, D_UP, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL turn_t3: got %0d,%0d dir%0d mv%0d pv%0d need 5,1 dir0 mv1 pv0",
               pac_x, pac_y, pac_dir, moving, dut.r_pend_v);
    end
  endtask

  task automatic test_blocked();
    do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd5, 5'd0, D_UP, 1'b1}) begin
      n_fail++;
      $display("FAIL block_t1: got %0d,%0d dir%0d mv%0d need 5,0 dir0 mv1", pac_x, pac_y, pac_dir, moving);
    end
    do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd5, 5'd0, D_UP, 1'b0}) begin
      n_fail++;
      $display("FAIL block_t2: got %0d,%0d dir%0d mv%0d need 5,0 dir0 mv0", pac_x, pac_y, pac_dir, moving);
    end
  endtask

  task automatic test_tunnel(output logic [4:0] end_x, output logic end_mv);
    press(D_DN);
    do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd5, 5'd1, D_DN, 1'b1}) begin
      n_fail++;
      $display("FAIL tun_down: got %0d,%0d dir%0d mv%0d need 5,1 dir1 mv1", pac_x, pac_y, pac_dir, moving);
    end
    do_tick();
    press(D_LT);
    for (int i = 0; i < 5; i++) do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd0, 5'd2, D_LT, 1'b1}) begin
      n_fail++;
      $display("FAIL tun_edge: got %0d,%0d dir%0d mv%0d need 0,2 dir2 mv1", pac_x, pac_y, pac_dir, moving);
    end
    do_tick();
`ifdef PAC_TUNNEL_WRAP_EN
    end_x = 5'd17;
    end_mv = 1'b1;
`else
    end_x = 5'd0;
    end_mv = 1'b0;
`endif
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {end_x, 5'd2, D_LT, end_mv}) begin
      n_fail++;
      $display("FAIL tun_cross: got %0d,%0d dir%0d mv%0d need %0d,2 dir2 mv%0d",
               pac_x, pac_y, pac_dir, moving, end_x, end_mv);
    end
  endtask

  task automatic test_freeze(input logic [4:0] ex, input logic emv);
    scene = 2'b10;
    btn_d = 1'b1;
    for (int i = 0; i < 4; i++) do_tick();
    scene = 2'b11;
    do_tick();
    btn_d = 1'b0;
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving, dut.r_pend_v} !== {ex, 5'd2, D_LT, emv, 1'b0}) begin
      n_fail++;
      $display("FAIL freeze: got %0d,%0d dir%0d mv%0d pv%0d need %0d,2 dir2 mv%0d pv0",
               pac_x, pac_y, pac_dir, moving, dut.r_pend_v, ex, emv);
    end
  endtask

  task automatic test_same_clock();
    scene = 2'b00;
    cyc();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd8, 5'd2, D_LT, 1'b0}) begin
      n_fail++;
      $display("FAIL rehome: got %0d,%0d dir%0d mv%0d need 8,2 dir2 mv0", pac_x, pac_y, pac_dir, moving);
    end
    scene = 2'b01;
    btn_u = 1'b1;
    display_cnt[22] = 1'b1;
    cyc();
    btn_u = 1'b0;
    display_cnt[22] = 1'b0;
    cyc();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving, dut.r_pend_v} !== {5'd7, 5'd2, D_LT, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL same_clk: got %0d,%0d dir%0d mv%0d pv%0d need 7,2 dir2 mv1 pv1",
               pac_x, pac_y, pac_dir, moving, dut.r_pend_v);
    end
    for (int i = 0; i < 3; i++) do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd5, 5'd1, D_UP, 1'b1}) begin
      n_fail++;
      $display("FAIL late_turn: got %0d,%0d dir%0d mv%0d need 5,1 dir0 mv1", pac_x, pac_y, pac_dir, moving);
    end
  endtask

  task automatic test_start_mid_play();
    do_tick();
    press(D_LT);
    do_tick();
    do_tick();
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd3, 5'd0, D_LT, 1'b1}) begin
      n_fail++;
      $display("FAIL reach_3_0: got %0d,%0d dir%0d mv%0d need 3,0 dir2 mv1", pac_x, pac_y, pac_dir, moving);
    end
    press(D_DN);
    scene = 2'b00;
    cyc();
    scene = 2'b01;
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving, dut.r_pend_v} !== {5'd8, 5'd2, D_LT, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL start_home: got %0d,%0d dir%0d mv%0d pv%0d need 8,2 dir2 mv0 pv0",
               pac_x, pac_y, pac_dir, moving, dut.r_pend_v);
    end
    cyc();
    n_chk++;
    if ({pac_x, pac_y, moving} !== {5'd8, 5'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL no_tick_hold: got %0d,%0d mv%0d need 8,2 mv0", pac_x, pac_y, moving);
    end
  endtask

  task automatic test_reset_mid_step();
    rst = 1'b1;
    display_cnt[22] = 1'b1;
    cyc();
    rst = 1'b0;
    display_cnt[22] = 1'b0;
    n_chk++;
    if ({pac_x, pac_y, pac_dir, moving} !== {5'd8, 5'd2, D_LT, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_step: got %0d,%0d dir%0d mv%0d need 8,2 dir2 mv0", pac_x, pac_y, pac_dir, moving);
    end
  endtask

  initial begin
    logic [4:0] tun_x;
    logic       tun_mv;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    scene = 2'b00;
    display_cnt = '0;
    {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
    cyc();
    test_reset();
    test_buffered_turn();
    test_blocked();
    test_tunnel(tun_x, tun_mv);
    test_freeze(tun_x, tun_mv);
    test_same_clock();
    test_start_mid_play();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
